sm4_rankey_gen_p: RTL



---
 rtl/sm4_rankey_gen_p.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sm4_rankey_gen_p.sv
// Parametrised LFSR key generator for SM4 key expansion: warm-up, refill, valid/ready handoff.
// Optional repeat checker enabled by defining SM4_KEYGEN_REPCHK_EN (adds o_rep_err).
module sm4_rankey_gen_p #(
  parameter int unsigned        LFSR_W       = 128,
  parameter logic [LFSR_W-1:0]  TAPS         = 128'hA000_0000_A000_0000_0000_0000_0000_0000,
  parameter int unsigned        STEP         = 8,
  parameter int unsigned        WARMUP_CYC   = 32,
  parameter logic [LFSR_W-1:0]  DEFAULT_SEED = 128'h9E3779B97F4A7C15F39D060BCE4E
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_key,
  output logic              o_key_valid,
  input  logic              i_key_ready,
  output logic              o_busy,
  output logic              o_seed_err
`ifdef SM4_KEYGEN_REPCHK_EN
  ,
  output logic              o_rep_err
`endif
);

  localparam int unsigned REFILL_CYC = LFSR_W / STEP;
  localparam int unsigned CNT_MAX    = (WARMUP_CYC > REFILL_CYC) ? WARMUP_CYC : REFILL_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] REFILL_LAST = CNT_W'(REFILL_CYC - 1);

  typedef enum logic [1:0] {StWarmup, StRefill, StHold} state_e;

  // STEP single-bit Fibonacci shifts, unrolled.
  function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] v;
    v = s;
    for (int unsigned i = 0; i < STEP; i++) begin
      v = {v[LFSR_W-2:0], ^(v & TAPS)};
    end
    return v;
  endfunction

  logic [LFSR_W-1:0] r_lfsr, w_lfsr_d;
  state_e            r_fsm, w_fsm_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [LFSR_W-1:0] r_key, w_key_d;
  logic              r_key_valid, w_key_valid_d;
  logic              r_seed_err, w_seed_err_d;

  logic [LFSR_W-1:0] w_stepped, w_adv_state;
  logic              w_lfsr_zero, w_xfer, w_cap;

`ifdef SM4_KEYGEN_REPCHK_EN
  logic [LFSR_W-1:0] r_hist, w_hist_d;
  logic              r_rep_err, w_rep_err_d;
`endif

  assign w_stepped   = f_step(r_lfsr);
  assign w_lfsr_zero = (r_lfsr == '0);
  // An upset to all-zero would lock the LFSR; recover by reloading the default seed.
  assign w_adv_state = w_lfsr_zero ? DEFAULT_SEED : w_stepped;
  assign w_xfer      = r_key_valid && i_key_ready;

  always_comb begin
    w_lfsr_d      = r_lfsr;
    w_fsm_d       = r_fsm;
    w_cnt_d       = r_cnt;
    w_key_d       = r_key;
    w_key_valid_d = r_key_valid;
    w_seed_err_d  = 1'b0;
    w_cap         = 1'b0;
`ifdef SM4_KEYGEN_REPCHK_EN
    w_hist_d      = r_hist;
    w_rep_err_d   = r_rep_err;
`endif

    if (i_en && w_lfsr_zero) begin
      w_lfsr_d = DEFAULT_SEED;
    end

    unique case (r_fsm)
      StWarmup: begin
        if (i_en) begin
          w_lfsr_d = w_adv_state;
          if (r_cnt == WARMUP_LAST) w_cap = 1'b1;
          else                      w_cnt_d = r_cnt + 1'b1;
        end
      end
      StRefill: begin
        if (i_en) begin
          w_lfsr_d = w_adv_state;
          if (r_cnt == REFILL_LAST) w_cap = 1'b1;
          else                      w_cnt_d = r_cnt + 1'b1;
        end
      end
      StHold: begin
        if (w_xfer) begin
          w_key_valid_d = 1'b0;
          w_cnt_d       = '0;
          w_fsm_d       = StRefill;
        end
      end
      default: w_fsm_d = StWarmup;
    endcase

    if (w_cap) begin
      w_cnt_d = '0;
`ifdef SM4_KEYGEN_REPCHK_EN
      if (w_adv_state == r_hist) begin
        w_rep_err_d = 1'b1;
        w_fsm_d     = StRefill;
      end else begin
        w_key_d       = w_adv_state;
        w_key_valid_d = 1'b1;
        w_hist_d      = w_adv_state;
        w_fsm_d       = StHold;
      end
`else
      w_key_d       = w_adv_state;
      w_key_valid_d = 1'b1;
      w_fsm_d       = StHold;
`endif
    end

    // Seed load wins over everything, including a same-cycle transfer.
    if (i_seed_load) begin
      w_lfsr_d      = (i_seed == '0) ? DEFAULT_SEED : i_seed;
      w_seed_err_d  = (i_seed == '0);
      w_key_valid_d = 1'b0;
      w_cnt_d       = '0;
      w_fsm_d       = StWarmup;
`ifdef SM4_KEYGEN_REPCHK_EN
      w_rep_err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr      <= DEFAULT_SEED;
      r_fsm       <= StWarmup;
      r_cnt       <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_seed_err  <= 1'b0;
    end else begin
      r_lfsr      <= w_lfsr_d;
      r_fsm       <= w_fsm_d;
      r_cnt       <= w_cnt_d;
      r_key       <= w_key_d;
      r_key_valid <= w_key_valid_d;
      r_seed_err  <= w_seed_err_d;
    end
  end

`ifdef SM4_KEYGEN_REPCHK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist    <= '0;
      r_rep_err <= 1'b0;
    end else begin
      r_hist    <= w_hist_d;
      r_rep_err <= w_rep_err_d;
    end
  end

  assign o_rep_err = r_rep_err;
`endif

  assign o_key       = r_key;
  assign o_key_valid = r_key_valid;
  assign o_seed_err  = r_seed_err;
  assign o_busy      = (r_fsm != StHold);

endmodule
